// File: rtl/pipelined_cla_adder_if.sv
// rtl/pipelined_cla_adder_if.sv - operand/result handshake bundle for pipelined_cla_adder
interface pipelined_cla_adder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero
    );
endinterface

// File: rtl/pipelined_cla_adder.sv
// rtl/pipelined_cla_adder.sv - pipelined two-level CLA adder/subtractor, one segment per stage
module pipelined_cla_segment #(
    parameter int GROUPS = 4
) (
    input  logic [4*GROUPS-1:0] a_i,
    input  logic [4*GROUPS-1:0] b_i,
    input  logic                c_i,
    output logic [4*GROUPS-1:0] s_o,
    output logic                c_o
);
    localparam int N = 4 * GROUPS;

    logic [N-1:0]      g;
    logic [N-1:0]      p;
    logic [N-1:0]      c;
    logic [GROUPS-1:0] grp_g;
    logic [GROUPS-1:0] grp_p;
    logic [GROUPS:0]   gc;
    logic              term;
    logic              prod;

    always_comb begin
        g     = a_i & b_i;
        p     = a_i | b_i;
        c     = '0;
        gc    = '0;
        grp_g = '0;
        grp_p = '0;
        term  = 1'b0;
        prod  = 1'b1;
        for (int j = 0; j < GROUPS; j++) begin
            term = 1'b0;
            prod = 1'b1;
            for (int i = 3; i >= 0; i--) begin
                term = term | (prod & g[4*j+i]);
                prod = prod & p[4*j+i];
            end
            grp_g[j] = term;
            grp_p[j] = prod;
        end
        // Second level: every group carry is a flat sum of products of group G/P and c_i.
        gc[0] = c_i;
        for (int j = 0; j < GROUPS; j++) begin
            term = 1'b0;
            prod = 1'b1;
            for (int m = j; m >= 0; m--) begin
                term = term | (prod & grp_g[m]);
                prod = prod & grp_p[m];
            end
            gc[j+1] = term | (prod & c_i);
        end
        for (int j = 0; j < GROUPS; j++) begin
            for (int i = 0; i < 4; i++) begin
                term = 1'b0;
                prod = 1'b1;
                for (int m = i - 1; m >= 0; m--) begin
                    term = term | (prod & g[4*j+m]);
                    prod = prod & p[4*j+m];
                end
                c[4*j+i] = term | (prod & gc[j]);
            end
        end
    end

    assign s_o = a_i ^ b_i ^ c;
    assign c_o = gc[GROUPS];
endmodule

module pipelined_cla_adder #(
    parameter int WIDTH            = 32,
    parameter int GROUPS_PER_STAGE = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pipelined_cla_adder_if.slave bus
);
    localparam int SEG    = 4 * GROUPS_PER_STAGE;
    localparam int STAGES = WIDTH / SEG;

    if (WIDTH % SEG != 0) begin : g_width_check
        $error("pipelined_cla_adder: WIDTH must be a multiple of 4*GROUPS_PER_STAGE");
    end

    logic advance;
    logic out_valid;
    logic cout_q;
    logic ovf_q;
    logic zero_q;

    // Global stall: the whole pipe moves only when the output slot is free or draining.
    assign advance      = !out_valid || bus.out_ready;
    assign bus.in_ready = advance;

    for (genvar k = 0; k < STAGES; k++) begin : stg
        localparam int LO = k * SEG;
        localparam int RW = WIDTH - LO;

        logic [RW-1:0]       a_in;
        logic [RW-1:0]       b_in;
        logic                c_in;
        logic                v_in;
        logic [SEG-1:0]      s_seg;
        logic                c_seg;
        logic [LO+SEG-1:0]   sum_d;
        logic [LO+SEG-1:0]   sum_q;
        logic                v_q;

        if (k == 0) begin : g_src
            assign a_in  = bus.a;
            assign b_in  = bus.sub ? ~bus.b : bus.b;
            assign c_in  = bus.sub | bus.cin;
            assign v_in  = bus.in_valid;
            assign sum_d = s_seg;
        end else begin : g_src
            assign a_in  = stg[k-1].g_skew.a_q;
            assign b_in  = stg[k-1].g_skew.b_q;
            assign c_in  = stg[k-1].g_skew.c_q;
            assign v_in  = stg[k-1].v_q;
            assign sum_d = {s_seg, stg[k-1].sum_q};
        end

        pipelined_cla_segment #(
            .GROUPS (GROUPS_PER_STAGE)
        ) u_seg (
            .a_i (a_in[SEG-1:0]),
            .b_i (b_in[SEG-1:0]),
            .c_i (c_in),
            .s_o (s_seg),
            .c_o (c_seg)
        );

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q   <= 1'b0;
                sum_q <= '0;
            end else if (advance) begin
                v_q <= v_in;
                if (v_in) begin
                    sum_q <= sum_d;
                end
            end
        end

        if (k < STAGES - 1) begin : g_skew
            logic [RW-SEG-1:0] a_q;
            logic [RW-SEG-1:0] b_q;
            logic              c_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                    c_q <= 1'b0;
                end else if (advance && v_in) begin
                    a_q <= a_in[RW-1:SEG];
                    b_q <= b_in[RW-1:SEG];
                    c_q <= c_seg;
                end
            end
        end else begin : g_last
            // Carry into the MSB is recovered from the MSB sum bit and its operands.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cout_q <= 1'b0;
                    ovf_q  <= 1'b0;
                    zero_q <= 1'b0;
                end else if (advance && v_in) begin
                    cout_q <= c_seg;
                    ovf_q  <= c_seg ^ (a_in[RW-1] ^ b_in[RW-1] ^ s_seg[SEG-1]);
                    zero_q <= (sum_d == '0);
                end
            end
        end
    end

    assign out_valid     = stg[STAGES-1].v_q;
    assign bus.out_valid = out_valid;
    assign bus.sum       = stg[STAGES-1].sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;
endmodule
